// File: rtl/sensor_tx_serializer_12bit_if.sv
// Pixel-word handshake between a pixel source and the 12-bit serializer.
// The source drives in_data/in_valid; the serializer answers with in_ready.
interface sensor_tx_serializer_12bit_if;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/sensor_tx_serializer_12bit.sv
// 12-bit MSB-first serializer with link training, a single-entry pixel hold
// register, word-rate clock/strobe generation and word/underrun counters.
module sensor_tx_serializer_12bit #(
  parameter logic [11:0] TRAIN_WORD = 12'h0FC,
  parameter int unsigned TRAIN_MIN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sensor_tx_serializer_12bit_if.slave   in_if,
  input  logic                          train_en,
  output logic                          ser_out,
  output logic                          word_clk,
  output logic                          word_start,
  output logic                          training,
  output logic [15:0]                   word_cnt,
  output logic [15:0]                   underrun_cnt
);

  typedef enum logic {
    S_TRAIN = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  localparam logic [7:0] TRAIN_MIN_C = 8'(TRAIN_MIN);
  localparam logic [3:0] LAST_BIT    = 4'd11;

  state_e      state_q,        state_d;
  logic [3:0]  bit_cnt_q,      bit_cnt_d;
  logic [11:0] shreg_q,        shreg_d;
  logic [7:0]  train_cnt_q,    train_cnt_d;
  logic        hold_full_q,    hold_full_d;
  logic [11:0] hold_data_q,    hold_data_d;
  logic [15:0] word_cnt_q,     word_cnt_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  logic        boundary;
  logic        in_ready_int;
  logic        hold_wr;
  logic        hold_rd;
  logic        run_load;
  logic [7:0]  train_cnt_inc;

  // Bit counter and word-boundary detection
  always_comb begin
    boundary  = (bit_cnt_q == LAST_BIT);
    bit_cnt_d = boundary ? '0 : bit_cnt_q + 4'd1;
  end

  // Hold register: written only while empty, read only while full
  always_comb begin
    in_ready_int = ~hold_full_q & rst_n;
    hold_wr      = in_if.in_valid & in_ready_int;
    hold_data_d  = hold_wr ? in_if.in_data : hold_data_q;
    hold_full_d  = hold_full_q;
    if (hold_wr) begin
      hold_full_d = 1'b1;
    end else if (hold_rd) begin
      hold_full_d = 1'b0;
    end
  end

  // Word sequencing: training/run decision and next-word selection at boundary
  always_comb begin
    state_d        = state_q;
    train_cnt_d    = train_cnt_q;
    shreg_d        = {shreg_q[10:0], 1'b0};
    word_cnt_d     = word_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    hold_rd        = 1'b0;
    run_load       = 1'b0;
    train_cnt_inc  = train_cnt_q + 8'd1;

    if (boundary) begin
      shreg_d = TRAIN_WORD;
      unique case (state_q)
        S_TRAIN: begin
          train_cnt_d = train_en ? '0 : train_cnt_inc;
          // The boundary that completes training already carries the run-state load.
          if (!train_en && (train_cnt_inc >= TRAIN_MIN_C)) begin
            state_d  = S_RUN;
            run_load = 1'b1;
          end
        end
        S_RUN: begin
          if (train_en) begin
            state_d     = S_TRAIN;
            train_cnt_d = '0;
          end else begin
            run_load = 1'b1;
          end
        end
        default: begin
          state_d = S_TRAIN;
        end
      endcase

      if (run_load) begin
        if (hold_full_q) begin
          shreg_d    = hold_data_q;
          hold_rd    = 1'b1;
          word_cnt_d = word_cnt_q + 16'd1;
        end else if (underrun_cnt_q != '1) begin
          underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_TRAIN;
      bit_cnt_q      <= '0;
      shreg_q        <= TRAIN_WORD;
      train_cnt_q    <= '0;
      hold_full_q    <= 1'b0;
      hold_data_q    <= '0;
      word_cnt_q     <= '0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      train_cnt_q    <= train_cnt_d;
      hold_full_q    <= hold_full_d;
      hold_data_q    <= hold_data_d;
      word_cnt_q     <= word_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  always_comb begin
    in_if.in_ready = in_ready_int;
    ser_out        = shreg_q[11];
    word_start     = (bit_cnt_q == 4'd0);
    word_clk       = (bit_cnt_q < 4'd6);
    training       = (state_q == S_TRAIN);
    word_cnt       = word_cnt_q;
    underrun_cnt   = underrun_cnt_q;
  end

endmodule

// File: tb/tb_sensor_tx_serializer_12bit.sv
// Directed bench for the 12-bit serializer: reset values, training, handshake,
// back-to-back data, re-training and mid-word reset.
module tb_sensor_tx_serializer_12bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        train_en;
  logic        ser_out;
  logic        word_clk;
  logic        word_start;
  logic        training;
  logic [15:0] word_cnt;
  logic [15:0] underrun_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int wnum   = 0;
  int mode   = 0;  // 0: leave inputs, 1: drop in_valid after accept, 2: increment in_data after accept

  sensor_tx_serializer_12bit_if bus ();

  sensor_tx_serializer_12bit #(
    .TRAIN_WORD (12'h0FC),
    .TRAIN_MIN  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_if        (bus),
    .train_en     (train_en),
    .ser_out      (ser_out),
    .word_clk     (word_clk),
    .word_start   (word_start),
    .training     (training),
    .word_cnt     (word_cnt),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge where bit 11 of the word is on ser_out.
  task automatic word(input logic [11:0] exp_data, input logic exp_tr, input logic [11:0] exp_rdy);
    logic [11:0] d, ws, wc, rdy;
    logic        tr, acc;
    tr = 1'b0;
    wnum++;
    for (int i = 0; i < 12; i++) begin
      #1;
      d[11-i]   = ser_out;
      ws[11-i]  = word_start;
      wc[11-i]  = word_clk;
      rdy[11-i] = bus.in_ready;
      if (i == 0) tr = training;
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc) begin
        if (mode == 1) bus.in_valid = 1'b0;
        else if (mode == 2) bus.in_data = bus.in_data + 12'd1;
      end
    end
    check($sformatf("w%0d data", wnum), 16'(d), 16'(exp_data));
    check($sformatf("w%0d training", wnum), 16'(tr), 16'(exp_tr));
    check($sformatf("w%0d word_start", wnum), 16'(ws), 16'h0800);
    check($sformatf("w%0d word_clk", wnum), 16'(wc), 16'h0FC0);
    check($sformatf("w%0d in_ready", wnum), 16'(rdy), 16'(exp_rdy));
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, " ser_out"},      16'(ser_out),      16'd0);
    check({tag, " word_clk"},     16'(word_clk),     16'd1);
    check({tag, " word_start"},   16'(word_start),   16'd1);
    check({tag, " training"},     16'(training),     16'd1);
    check({tag, " in_ready"},     16'(bus.in_ready), 16'd0);
    check({tag, " word_cnt"},     word_cnt,          16'd0);
    check({tag, " underrun_cnt"}, underrun_cnt,      16'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    train_en     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    reset_outputs("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle link: four training words, then underruns
    word(12'h0FC, 1'b1, 12'hFFF);
    word(12'h0FC, 1'b1, 12'hFFF);
    word(12'h0FC, 1'b1, 12'hFFF);
    #1 check("idle underrun w4", underrun_cnt, 16'd0);
    word(12'h0FC, 1'b1, 12'hFFF);
    #1 check("idle underrun w5", underrun_cnt, 16'd1);
    word(12'h0FC, 1'b0, 12'hFFF);
    #1 check("idle underrun w6", underrun_cnt, 16'd2);
    word(12'h0FC, 1'b0, 12'hFFF);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1 reset_outputs("rst1");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wnum  = 0;

    // Word offered during training waits and goes out as word 5
    word(12'h0FC, 1'b1, 12'hFFF);
    bus.in_data  = 12'hABC;
    bus.in_valid = 1'b1;
    mode         = 1;
    word(12'h0FC, 1'b1, 12'h800);
    word(12'h0FC, 1'b1, 12'h000);
    word(12'h0FC, 1'b1, 12'h000);
    #1 check("abc word_cnt", word_cnt, 16'd1);
    check("abc underrun", underrun_cnt, 16'd0);
    word(12'hABC, 1'b0, 12'hFFF);
    #1 check("post abc underrun", underrun_cnt, 16'd1);
    word(12'h0FC, 1'b0, 12'hFFF);

    // Back-to-back stream
    #1 check("stream underrun start", underrun_cnt, 16'd2);
    bus.in_data  = 12'h001;
    bus.in_valid = 1'b1;
    mode         = 2;
    word(12'h0FC, 1'b0, 12'h800);
    #1 check("stream word_cnt w8", word_cnt, 16'd2);
    word(12'h001, 1'b0, 12'h800);
    word(12'h002, 1'b0, 12'h800);
    word(12'h003, 1'b0, 12'h800);

    // Re-training with 555 held across it
    bus.in_data = 12'h555;
    mode        = 1;
    train_en    = 1'b1;
    #1 check("stream word_cnt w11", word_cnt, 16'd5);
    check("stream underrun end", underrun_cnt, 16'd2);
    word(12'h004, 1'b0, 12'h800);
    train_en = 1'b0;
    word(12'h0FC, 1'b1, 12'h000);
    word(12'h0FC, 1'b1, 12'h000);
    word(12'h0FC, 1'b1, 12'h000);
    #1 check("retrain word_cnt", word_cnt, 16'd5);
    word(12'h0FC, 1'b1, 12'h000);
    #1 check("555 word_cnt", word_cnt, 16'd6);
    check("555 underrun", underrun_cnt, 16'd2);
    word(12'h555, 1'b0, 12'hFFF);

    // Reset in the middle of a data word with the hold register full
    bus.in_data  = 12'h321;
    bus.in_valid = 1'b1;
    #1 check("w17 underrun", underrun_cnt, 16'd3);
    word(12'h0FC, 1'b0, 12'h800);
    bus.in_data  = 12'h777;
    bus.in_valid = 1'b1;
    #1 check("w18 in_ready bit0", 16'(bus.in_ready), 16'd1);
    check("w18 ser_out bit0", 16'(ser_out), 16'd0);
    check("w18 word_cnt", word_cnt, 16'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("w18 ser_out bit1", 16'(ser_out), 16'd0);
    @(negedge clk);
    #1 check("w18 ser_out bit2", 16'(ser_out), 16'd1);
    repeat (3) @(negedge clk);
    #1 check("w18 in_ready bit5", 16'(bus.in_ready), 16'd0);
    check("w18 word_clk bit5", 16'(word_clk), 16'd1);
    check("w18 word_start bit5", 16'(word_start), 16'd0);
    rst_n = 1'b0;
    #1 reset_outputs("rst2");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wnum  = 0;
    word(12'h0FC, 1'b1, 12'hFFF);
    word(12'h0FC, 1'b1, 12'hFFF);
    word(12'h0FC, 1'b1, 12'hFFF);
    word(12'h0FC, 1'b1, 12'hFFF);
    #1 check("rst2 word_cnt w5", word_cnt, 16'd0);
    check("rst2 underrun w5", underrun_cnt, 16'd1);
    word(12'h0FC, 1'b0, 12'hFFF);
    #1 check("rst2 word_cnt w6", word_cnt, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
